// File: rtl/mod_regfile_write_arbiter.sv
// Register-file write-port arbiter: the writeback stage has fixed priority; multiply/divide
// results are buffered in a small FIFO and drained into idle write slots. A scoreboard of
// in-flight MD destinations drives the decode stall outputs.
module mod_regfile_write_arbiter #(
    parameter int unsigned MD_FIFO_DEPTH = 2,
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned DATA_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              md_issue,
    input  logic [ADDR_W-1:0] md_issue_addr,
    input  logic              md_valid,
    input  logic [ADDR_W-1:0] md_addr,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    input  logic [ADDR_W-1:0] read_address_1,
    input  logic [ADDR_W-1:0] read_address_2,
    output logic              stall_1,
    output logic              stall_2,
    output logic              sb_conflict,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_write_address,
    output logic [DATA_W-1:0] rf_write_data
);

    localparam int unsigned PTR_W = (MD_FIFO_DEPTH > 1) ? $clog2(MD_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(MD_FIFO_DEPTH + 1);
    localparam int unsigned NREG  = 1 << ADDR_W;

    logic [ADDR_W-1:0] fifo_addr [MD_FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [MD_FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    // Bit 0 exists only to keep indexing simple; it is forced to zero and never read as set.
    logic [NREG-1:0]  pending_q, pending_d;

    logic wb_win;
    logic fifo_empty;
    logic push;
    logic pop;

    assign fifo_empty = (count_q == '0);
    assign md_ready   = (count_q < CNT_W'(MD_FIFO_DEPTH));
    // Reset gating keeps the write port quiet while reset is asserted, even if WB is driving.
    assign wb_win     = wb_valid & ~hold & ~reset & (wb_addr != '0);
    assign pop        = ~wb_win & ~hold & ~reset & ~fifo_empty;
    // Address-0 results complete the handshake but are dropped.
    assign push       = md_valid & md_ready & (md_addr != '0);

    // Write-port mux: WB first, then FIFO head, else idle with zeroed address/data.
    always_comb begin
        rf_write         = 1'b0;
        rf_write_address = '0;
        rf_write_data    = '0;
        if (wb_win) begin
            rf_write         = 1'b1;
            rf_write_address = wb_addr;
            rf_write_data    = wb_data;
        end else if (pop) begin
            rf_write         = 1'b1;
            rf_write_address = fifo_addr[rd_ptr_q];
            rf_write_data    = fifo_data[rd_ptr_q];
        end
    end

    // Decode stalls and WAW detection straight off the scoreboard.
    always_comb begin
        stall_1     = (read_address_1 != '0) & pending_q[read_address_1];
        stall_2     = (read_address_2 != '0) & pending_q[read_address_2];
        sb_conflict = wb_win & pending_q[wb_addr];
    end

    // FIFO pointer/count next state; simultaneous push and pop leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Scoreboard next state; the set is applied after the clear so a same-address set wins.
    always_comb begin
        pending_d = pending_q;
        if (pop) pending_d[fifo_addr[rd_ptr_q]] = 1'b0;
        if (md_issue && (md_issue_addr != '0)) pending_d[md_issue_addr] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    // FIFO storage; contents are don't-care while the count marks them invalid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= md_addr;
            fifo_data[wr_ptr_q] <= md_data;
        end
    end

endmodule

// File: doc/mod_regfile_write_arbiter.md
Name: mod_regfile_write_arbiter

Overview:
- Shares the single register-file write port between two sources:
  - the in-order pipeline writeback (WB), which has fixed priority and is never back-pressured;
  - the multi-cycle multiply/divide unit (MD), whose results go into a small FIFO and drain into free write slots.
- Holds a scoreboard of destination registers with MD results in flight, so decode can stall on reads of those registers.
- Sits between the writeback stage, the MD unit and the register file write inputs (write, write_address, write_data).

Parameters:
- MD_FIFO_DEPTH, 2, MD result buffer entries (power of 2, at least 2).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- hold  in  1  pipeline freeze; no writes are issued and nothing is popped while high.
- wb_valid  in  1  WB has a result this cycle.
- wb_addr  in  ADDR_W  WB destination register.
- wb_data  in  DATA_W  WB result.
- md_issue  in  1  MD operation issued this cycle; marks md_issue_addr pending.
- md_issue_addr  in  ADDR_W  destination of the issued MD operation.
- md_valid  in  1  MD result available.
- md_addr  in  ADDR_W  MD result destination.
- md_data  in  DATA_W  MD result.
- md_ready  out  1  FIFO can accept an MD result.
- read_address_1  in  ADDR_W  decode source register 1.
- read_address_2  in  ADDR_W  decode source register 2.
- stall_1  out  1  read_address_1 is pending.
- stall_2  out  1  read_address_2 is pending.
- sb_conflict  out  1  WB is writing a register that is still pending (WAW).
- rf_write  out  1  register file write enable.
- rf_write_address  out  ADDR_W  register file write address.
- rf_write_data  out  DATA_W  register file write data.

Behaviour:
- State:
  - FIFO of {addr, data} with read/write pointers and a count.
  - pending[31:1] scoreboard; there is no bit for address 0.
- Reset (async assert):
  - FIFO empty, pending all zero.
  - Outputs during reset: md_ready=1, stall_1=0, stall_2=0, sb_conflict=0, rf_write=0, address and data 0.
  - Reset mid-operation discards buffered results and pending bits without writing them.
- Write-port selection (combinational, same cycle):
  - wb_win = wb_valid & !hold & (wb_addr != 0).
  - If wb_win: rf_write=1, address/data taken from WB.
  - Else if !hold and FIFO non-empty: rf_write=1, address/data taken from the FIFO head, and the head is popped at the clock edge.
  - Else: rf_write=0, address/data 0.
  - WB with address 0 is dropped and does not consume the slot.
- MD handshake:
  - md_ready = (count < MD_FIFO_DEPTH).
  - Push on posedge when md_valid & md_ready.
  - md_addr == 0 is accepted (ready honoured) but not pushed.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - When full, md_ready=0; md_valid may remain high and md_addr/md_data must be held stable by the MD unit.
  - Minimum MD latency, input to rf_write: 1 cycle (no bypass).
  - Pointers wrap modulo MD_FIFO_DEPTH.
- Scoreboard:
  - md_issue with md_issue_addr != 0 sets pending[addr].
  - A FIFO pop clears pending[popped addr].
  - Set and clear of the same address in the same cycle: set wins.
  - stall_n = (read_address_n != 0) & pending[read_address_n], combinational.
  - sb_conflict = wb_win & pending[wb_addr]. The WB write is still performed; the pending bit is unchanged.
- hold high:
  - No rf_write and no pop.
  - Push, md_issue and the stall outputs operate normally.

Test Plan:
- Reset asserted between clock edges with 2 entries buffered and pending[5]=1 -> immediately md_ready=1, stall_1=0 for read_address_1=5, and no rf_write afterwards.
- md_issue addr 7; 3 cycles later md_valid addr 7, data 0xDEADBEEF, WB idle -> stall_1=1 on r7 from the cycle after issue; next cycle rf_write=1, addr 7, data 0xDEADBEEF; stall_1=0 the cycle after.
- WB valid every cycle (r3 = 1, 2, 3...) while MD pushes r9 and r10 -> md_ready=0 after 2 pushes; all WB writes go out in order; r9 then r10 drain in the first two WB-idle cycles; count returns to 0.
- Push and pop in the same cycle with FIFO at depth 1 -> count stays 1; pointers wrap correctly across 5 consecutive such cycles.
- hold=1 for 3 cycles with FIFO non-empty and wb_valid=1 -> rf_write=0 throughout; after release the WB write occurs first, then the FIFO entry.
- wb_valid addr 0, data 0x55, with FIFO holding r4 -> the r4 write is issued that cycle; md_issue addr 0 never stalls; WB to r4 while r4 is pending -> sb_conflict=1 and the write occurs.
